// File: rtl/barvinn_top.sv
// barvinn_top: per-hart MVU CSR banks, job dispatch and completion interrupts.
//
// Each hart owns one MVU. A CSR access from the core carries the hart index,
// which selects the bank. Config registers drive the MVU buses directly.
// COMMAND launches a job with a one-cycle start pulse. STATUS tracks busy,
// the pending interrupt, the interrupt enable and a command-while-busy error.
//
// Handshake: there is no valid/ready flow control. csr_wr_en and csr_rd_en
// are single-cycle strobes that are always accepted; read data is registered
// and appears on csr_rdata exactly one cycle after the strobe.
// mvu_start and mvu_done are single-cycle pulses.
// Each bank exposes its job state (busy) through STATUS bit 1.
module barvinn_top #(
    parameter int N_HARTS = 8,
    parameter int HART_W  = 3,
    parameter int XLEN    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_wr_en,
    input  logic                  csr_rd_en,
    input  logic [HART_W-1:0]     csr_hart,
    input  logic [11:0]           csr_addr,
    input  logic [XLEN-1:0]       csr_wdata,
    output logic [XLEN-1:0]       csr_rdata,
    output logic [N_HARTS-1:0]    mvu_start,
    output logic [N_HARTS*9-1:0]  mvu_wbaseaddr,
    output logic [N_HARTS*15-1:0] mvu_ibaseaddr,
    output logic [N_HARTS*15-1:0] mvu_obaseaddr,
    output logic [N_HARTS*6-1:0]  mvu_wprecision,
    output logic [N_HARTS*6-1:0]  mvu_iprecision,
    output logic [N_HARTS*6-1:0]  mvu_oprecision,
    output logic [N_HARTS*5-1:0]  mvu_quant_msbidx,
    output logic [N_HARTS*15-1:0] mvu_countdown,
    input  logic [N_HARTS-1:0]    mvu_done,
    output logic [N_HARTS-1:0]    irq
);

    localparam logic [11:0] A_WBASE  = 12'hF20;
    localparam logic [11:0] A_IBASE  = 12'hF21;
    localparam logic [11:0] A_OBASE  = 12'hF22;
    localparam logic [11:0] A_WPREC  = 12'hF23;
    localparam logic [11:0] A_IPREC  = 12'hF24;
    localparam logic [11:0] A_OPREC  = 12'hF25;
    localparam logic [11:0] A_QMSB   = 12'hF26;
    localparam logic [11:0] A_CNT    = 12'hF27;
    localparam logic [11:0] A_CMD    = 12'hF28;
    localparam logic [11:0] A_STATUS = 12'hF29;

    // Config banks, one entry per hart/MVU
    logic [8:0]  r_wbase [N_HARTS];
    logic [14:0] r_ibase [N_HARTS];
    logic [14:0] r_obase [N_HARTS];
    logic [5:0]  r_wprec [N_HARTS];
    logic [5:0]  r_iprec [N_HARTS];
    logic [5:0]  r_oprec [N_HARTS];
    logic [4:0]  r_qmsb  [N_HARTS];
    logic [14:0] r_cnt   [N_HARTS];

    // Status and dispatch state
    logic [N_HARTS-1:0] r_busy;
    logic [N_HARTS-1:0] r_irq_pend;
    logic [N_HARTS-1:0] r_irq_en;
    logic [N_HARTS-1:0] r_cmd_err;
    logic [N_HARTS-1:0] r_start;
    logic [XLEN-1:0]    r_rdata;

    // Per-bank write decode
    logic [N_HARTS-1:0] w_sel;
    logic [N_HARTS-1:0] w_cmd_wr;
    logic [N_HARTS-1:0] w_accept;
    logic [N_HARTS-1:0] w_cfg_wr;
    logic [N_HARTS-1:0] w_status_wr;
    logic [XLEN-1:0]    w_rd_mux;

    // Only field-width low bits of the write data are ever stored
    logic w_unused;
    assign w_unused = &{1'b0, csr_wdata[XLEN-1:15]};

    // Decode the single CSR write into per-bank strobes; a command is
    // accepted when idle or when the running job finishes this same cycle
    always_comb begin
        w_sel       = '0;
        w_cmd_wr    = '0;
        w_accept    = '0;
        w_cfg_wr    = '0;
        w_status_wr = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            w_sel[h]       = csr_wr_en && (csr_hart == HART_W'(h));
            w_cmd_wr[h]    = w_sel[h] && (csr_addr == A_CMD);
            w_accept[h]    = w_cmd_wr[h] && (!r_busy[h] || mvu_done[h]);
            w_status_wr[h] = w_sel[h] && (csr_addr == A_STATUS);
            w_cfg_wr[h]    = w_sel[h] && !r_busy[h];
        end
    end

    // Config registers: writes are truncated and frozen while the MVU is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < N_HARTS; h++) begin
                r_wbase[h] <= '0;
                r_ibase[h] <= '0;
                r_obase[h] <= '0;
                r_wprec[h] <= '0;
                r_iprec[h] <= '0;
                r_oprec[h] <= '0;
                r_qmsb[h]  <= '0;
                r_cnt[h]   <= '0;
            end
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (w_cfg_wr[h]) begin
                    case (csr_addr)
                        A_WBASE: r_wbase[h] <= csr_wdata[8:0];
                        A_IBASE: r_ibase[h] <= csr_wdata[14:0];
                        A_OBASE: r_obase[h] <= csr_wdata[14:0];
                        A_WPREC: r_wprec[h] <= csr_wdata[5:0];
                        A_IPREC: r_iprec[h] <= csr_wdata[5:0];
                        A_OPREC: r_oprec[h] <= csr_wdata[5:0];
                        A_QMSB:  r_qmsb[h]  <= csr_wdata[4:0];
                        A_CNT:   r_cnt[h]   <= csr_wdata[14:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Job dispatch, busy tracking and status bits; done-set beats write-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_irq_pend <= '0;
            r_irq_en   <= '0;
            r_cmd_err  <= '0;
            r_start    <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                r_start[h] <= w_accept[h];

                if (w_accept[h]) begin
                    r_busy[h] <= 1'b1;
                end else if (mvu_done[h]) begin
                    r_busy[h] <= 1'b0;
                end

                if (mvu_done[h]) begin
                    r_irq_pend[h] <= 1'b1;
                end else if (w_status_wr[h] && csr_wdata[0]) begin
                    r_irq_pend[h] <= 1'b0;
                end

                if (w_status_wr[h]) begin
                    r_irq_en[h] <= csr_wdata[2];
                end

                if (w_cmd_wr[h] && !w_accept[h]) begin
                    r_cmd_err[h] <= 1'b1;
                end else if (w_status_wr[h] && csr_wdata[3]) begin
                    r_cmd_err[h] <= 1'b0;
                end
            end
        end
    end

    // Read mux over the selected bank, zero-extended; unmapped reads as 0
    always_comb begin
        w_rd_mux = '0;
        case (csr_addr)
            A_WBASE:  w_rd_mux = XLEN'(r_wbase[csr_hart]);
            A_IBASE:  w_rd_mux = XLEN'(r_ibase[csr_hart]);
            A_OBASE:  w_rd_mux = XLEN'(r_obase[csr_hart]);
            A_WPREC:  w_rd_mux = XLEN'(r_wprec[csr_hart]);
            A_IPREC:  w_rd_mux = XLEN'(r_iprec[csr_hart]);
            A_OPREC:  w_rd_mux = XLEN'(r_oprec[csr_hart]);
            A_QMSB:   w_rd_mux = XLEN'(r_qmsb[csr_hart]);
            A_CNT:    w_rd_mux = XLEN'(r_cnt[csr_hart]);
            A_STATUS: w_rd_mux = XLEN'({r_cmd_err[csr_hart], r_irq_en[csr_hart],
                                        r_busy[csr_hart], r_irq_pend[csr_hart]});
            default:  w_rd_mux = '0;
        endcase
    end

    // Registered read data reflects state before this cycle's write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= csr_rd_en ? w_rd_mux : '0;
        end
    end

    assign csr_rdata = r_rdata;
    assign mvu_start = r_start;
    assign irq       = r_irq_pend & r_irq_en;

    // Pack per-MVU config onto the flat buses, MVU0 in the LSBs
    for (genvar g = 0; g < N_HARTS; g++) begin : g_pack
        assign mvu_wbaseaddr[g*9 +: 9]     = r_wbase[g];
        assign mvu_ibaseaddr[g*15 +: 15]   = r_ibase[g];
        assign mvu_obaseaddr[g*15 +: 15]   = r_obase[g];
        assign mvu_wprecision[g*6 +: 6]    = r_wprec[g];
        assign mvu_iprecision[g*6 +: 6]    = r_iprec[g];
        assign mvu_oprecision[g*6 +: 6]    = r_oprec[g];
        assign mvu_quant_msbidx[g*5 +: 5]  = r_qmsb[g];
        assign mvu_countdown[g*15 +: 15]   = r_cnt[g];
    end

endmodule

// File: tb/tb_barvinn_top.sv
// Bench for barvinn_top: directed table from the test plan plus random traffic
// checked against a per-hart register model.
module tb_barvinn_top;

    logic         clk = 1'b0;
    logic         rst;
    logic         csr_wr_en;
    logic         csr_rd_en;
    logic [2:0]   csr_hart;
    logic [11:0]  csr_addr;
    logic [31:0]  csr_wdata;
    logic [31:0]  csr_rdata;
    logic [7:0]   mvu_start;
    logic [71:0]  mvu_wbaseaddr;
    logic [119:0] mvu_ibaseaddr;
    logic [119:0] mvu_obaseaddr;
    logic [47:0]  mvu_wprecision;
    logic [47:0]  mvu_iprecision;
    logic [47:0]  mvu_oprecision;
    logic [39:0]  mvu_quant_msbidx;
    logic [119:0] mvu_countdown;
    logic [7:0]   mvu_done;
    logic [7:0]   irq;

    barvinn_top dut (
        .clk              (clk),
        .rst              (rst),
        .csr_wr_en        (csr_wr_en),
        .csr_rd_en        (csr_rd_en),
        .csr_hart         (csr_hart),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .mvu_start        (mvu_start),
        .mvu_wbaseaddr    (mvu_wbaseaddr),
        .mvu_ibaseaddr    (mvu_ibaseaddr),
        .mvu_obaseaddr    (mvu_obaseaddr),
        .mvu_wprecision   (mvu_wprecision),
        .mvu_iprecision   (mvu_iprecision),
        .mvu_oprecision   (mvu_oprecision),
        .mvu_quant_msbidx (mvu_quant_msbidx),
        .mvu_countdown    (mvu_countdown),
        .mvu_done         (mvu_done),
        .irq              (irq)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: config fields per hart, status flags per hart
    int          fw [8] = '{9, 15, 15, 6, 6, 6, 5, 15};
    logic [14:0] m_cfg [8][8];
    bit          m_busy [8];
    bit          m_pend [8];
    bit          m_en   [8];
    bit          m_err  [8];

    logic [31:0] exp_rdata;
    logic [7:0]  exp_start;
    logic [7:0]  exp_irq;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 8; h++) begin
            for (int f = 0; f < 8; f++) m_cfg[h][f] = '0;
            m_busy[h] = 0;
            m_pend[h] = 0;
            m_en[h]   = 0;
            m_err[h]  = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input int h, input logic [11:0] a);
        int idx;
        idx = int'(a) - 'hF20;
        if (idx >= 0 && idx <= 7) return 32'(m_cfg[h][idx]);
        if (a == 12'hF29) return {28'd0, m_err[h], m_en[h], m_busy[h], m_pend[h]};
        return 32'd0;
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input bit r, input bit wr, input bit rd, input int h,
                        input logic [11:0] a, input logic [31:0] wd, input logic [7:0] dn);
        int idx;
        logic [76:0] got_bus;
        logic [76:0] exp_bus;
        exp_rdata = '0;
        exp_start = '0;
        if (r) begin
            model_reset();
        end else begin
            if (rd) exp_rdata = model_read(h, a);
            idx = int'(a) - 'hF20;
            for (int k = 0; k < 8; k++) begin
                bit mine;
                bit launch;
                bit can_go;
                bit stw;
                mine   = wr && (h == k);
                launch = mine && (a == 12'hF28);
                can_go = !m_busy[k] || dn[k];
                stw    = mine && (a == 12'hF29);
                if (mine && !m_busy[k] && idx >= 0 && idx <= 7)
                    m_cfg[k][idx] = 15'(wd & ((32'd1 << fw[idx]) - 1));
                if (launch && !can_go) m_err[k] = 1;
                else if (stw && wd[3]) m_err[k] = 0;
                if (stw) m_en[k] = wd[2];
                if (dn[k]) m_pend[k] = 1;
                else if (stw && wd[0]) m_pend[k] = 0;
                if (launch && can_go) begin
                    exp_start[k] = 1'b1;
                    m_busy[k] = 1;
                end else if (dn[k]) begin
                    m_busy[k] = 0;
                end
            end
        end
        for (int k = 0; k < 8; k++) exp_irq[k] = m_pend[k] && m_en[k];

        rst       = r;
        csr_wr_en = wr;
        csr_rd_en = rd;
        csr_hart  = 3'(h);
        csr_addr  = a;
        csr_wdata = wd;
        mvu_done  = dn;
        @(posedge clk);
        #1;
        chk("rdata", 128'(csr_rdata), 128'(exp_rdata));
        chk("start", 128'(mvu_start), 128'(exp_start));
        chk("irq",   128'(irq),       128'(exp_irq));
        for (int k = 0; k < 8; k++) begin
            got_bus = {mvu_wbaseaddr[k*9 +: 9], mvu_ibaseaddr[k*15 +: 15],
                       mvu_obaseaddr[k*15 +: 15], mvu_wprecision[k*6 +: 6],
                       mvu_iprecision[k*6 +: 6], mvu_oprecision[k*6 +: 6],
                       mvu_quant_msbidx[k*5 +: 5], mvu_countdown[k*15 +: 15]};
            exp_bus = {m_cfg[k][0][8:0], m_cfg[k][1], m_cfg[k][2], m_cfg[k][3][5:0],
                       m_cfg[k][4][5:0], m_cfg[k][5][5:0], m_cfg[k][6][4:0], m_cfg[k][7]};
            chk($sformatf("bus%0d", k), 128'(got_bus), 128'(exp_bus));
        end
    endtask

    // Directed vectors with hand-derived expectations (seen one cycle after apply)
    typedef struct {
        bit          rst;
        bit          wr;
        bit          rd;
        int          hart;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [7:0]  done;
        logic [31:0] e_rdata;
        logic [7:0]  e_start;
        logic [7:0]  e_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit wr, input bit rd, input int h,
                       input logic [11:0] a, input logic [31:0] wd, input logic [7:0] dn,
                       input logic [31:0] er, input logic [7:0] es, input logic [7:0] ei);
        vec_t v;
        v = '{r, wr, rd, h, a, wd, dn, er, es, ei};
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; csr_wr_en = 0; csr_rd_en = 0; csr_hart = 0;
        csr_addr = 0; csr_wdata = 0; mvu_done = 0;

        //  rst wr rd h  addr     wdata     done   rdata     start  irq
        add(1, 0, 0, 0, 12'h000, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 0, 12'hF29, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 1, 0, 3, 12'hF20, 32'h1FF,  8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 1, 0, 3, 12'hF21, 32'h7FFF, 8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 1, 0, 3, 12'hF25, 32'h3F,   8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 1, 0, 3, 12'hF27, 32'hFFFF, 8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 3, 12'hF20, 32'h0,    8'h00, 32'h1FF,  8'h00, 8'h00);
        add(0, 0, 1, 3, 12'hF21, 32'h0,    8'h00, 32'h7FFF, 8'h00, 8'h00);
        add(0, 0, 1, 3, 12'hF25, 32'h0,    8'h00, 32'h3F,   8'h00, 8'h00);
        add(0, 0, 1, 3, 12'hF27, 32'h0,    8'h00, 32'h7FFF, 8'h00, 8'h00);
        add(0, 0, 1, 2, 12'hF20, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 3, 12'hF30, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        // hart 5 job, second command while busy, config write while busy
        add(0, 1, 0, 5, 12'hF28, 32'h1,    8'h00, 32'h0,    8'h20, 8'h00);
        add(0, 0, 1, 5, 12'hF29, 32'h0,    8'h00, 32'h2,    8'h00, 8'h00);
        add(0, 1, 0, 5, 12'hF28, 32'h1,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 5, 12'hF29, 32'h0,    8'h00, 32'hA,    8'h00, 8'h00);
        add(0, 1, 0, 5, 12'hF20, 32'h55,   8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 5, 12'hF20, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 5, 12'hF28, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        // clear cmd_err, enable irq, then done
        add(0, 1, 0, 5, 12'hF29, 32'hC,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 0, 5, 12'h000, 32'h0,    8'h20, 32'h0,    8'h00, 8'h20);
        add(0, 0, 1, 5, 12'hF29, 32'h0,    8'h00, 32'h5,    8'h00, 8'h20);
        add(0, 1, 0, 5, 12'hF29, 32'h5,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 5, 12'hF29, 32'h0,    8'h00, 32'h4,    8'h00, 8'h00);
        // done and clear in the same cycle: set wins
        add(0, 1, 0, 5, 12'hF29, 32'h5,    8'h20, 32'h0,    8'h00, 8'h20);
        add(0, 0, 1, 5, 12'hF29, 32'h0,    8'h00, 32'h5,    8'h00, 8'h20);
        add(0, 1, 0, 5, 12'hF29, 32'h1,    8'h00, 32'h0,    8'h00, 8'h00);
        // hart 1: command accepted in the same cycle as done
        add(0, 1, 0, 1, 12'hF28, 32'h0,    8'h00, 32'h0,    8'h02, 8'h00);
        add(0, 1, 0, 1, 12'hF28, 32'h0,    8'h02, 32'h0,    8'h02, 8'h00);
        add(0, 0, 1, 1, 12'hF29, 32'h0,    8'h00, 32'h3,    8'h00, 8'h00);
        // hart 7 busy with irq_en, then reset, then late done
        add(0, 1, 0, 7, 12'hF29, 32'h4,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 1, 0, 7, 12'hF28, 32'h0,    8'h00, 32'h0,    8'h80, 8'h00);
        add(0, 0, 1, 7, 12'hF29, 32'h0,    8'h00, 32'h6,    8'h00, 8'h00);
        add(1, 1, 1, 7, 12'hF28, 32'h0,    8'h80, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 7, 12'hF29, 32'h0,    8'h00, 32'h0,    8'h00, 8'h00);
        add(0, 0, 0, 7, 12'h000, 32'h0,    8'h80, 32'h0,    8'h00, 8'h00);
        add(0, 0, 1, 7, 12'hF29, 32'h0,    8'h00, 32'h1,    8'h00, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].hart, tbl[i].addr,
                 tbl[i].wdata, tbl[i].done);
            chk($sformatf("v%0d_rdata", i), 128'(csr_rdata), 128'(tbl[i].e_rdata));
            chk($sformatf("v%0d_start", i), 128'(mvu_start), 128'(tbl[i].e_start));
            chk($sformatf("v%0d_irq", i),   128'(irq),       128'(tbl[i].e_irq));
            if (i == 9) begin
                chk("wbase3", 128'(mvu_wbaseaddr[35:27]),  128'(9'h1FF));
                chk("ibase3", 128'(mvu_ibaseaddr[59:45]),  128'(15'h7FFF));
                chk("oprec3", 128'(mvu_oprecision[23:18]), 128'(6'h3F));
                chk("cnt3",   128'(mvu_countdown[59:45]),  128'(15'h7FFF));
                chk("wbase2", 128'(mvu_wbaseaddr[26:18]),  128'(9'h0));
            end
        end

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit          r;
            logic [31:0] wd;
            logic [7:0]  dn;
            r  = ($urandom_range(0, 199) == 0);
            wd = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
            dn = 8'($urandom & $urandom & $urandom);
            step(r, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), 12'(12'hF1E + $urandom_range(0, 12)), wd, dn);
        end

        step(0, 0, 0, 0, 12'h0, 32'h0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barvinn_top.md
Name: barvinn_top

Overview:
- Glue layer between the 8-hart pito barrel RISC-V core and the array of 8 MVUs (matrix-vector units).
- Each hart owns one MVU through a private bank of MVU CSRs: hart CSR writes configure its MVU and launch jobs.
- MVU completion is returned to the owning hart as a per-hart interrupt.
- Core, MVU datapaths and memories are outside this block; it holds only the CSR banks, job dispatch and interrupt logic.

Parameters:
N_HARTS, 8, number of harts, equal to the number of MVUs (power of 2)
HART_W, 3, hart index width, log2(N_HARTS)
XLEN, 32, CSR data width

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous active-high reset
csr_wr_en  in  1  CSR write strobe from core
csr_rd_en  in  1  CSR read strobe from core
csr_hart  in  HART_W  hart issuing the access
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  write data
csr_rdata  out  XLEN  read data, valid 1 cycle after csr_rd_en
mvu_start  out  N_HARTS  one-cycle job start pulse per MVU
mvu_wbaseaddr  out  N_HARTS*9  weight base address per MVU, concatenated with MVU0 in the LSBs (same packing for all per-MVU buses)
mvu_ibaseaddr  out  N_HARTS*15  input base address
mvu_obaseaddr  out  N_HARTS*15  output base address
mvu_wprecision  out  N_HARTS*6  weight precision
mvu_iprecision  out  N_HARTS*6  input precision
mvu_oprecision  out  N_HARTS*6  output precision
mvu_quant_msbidx  out  N_HARTS*5  quantizer MSB index
mvu_countdown  out  N_HARTS*15  job length
mvu_done  in  N_HARTS  one-cycle job-complete pulse per MVU
irq  out  N_HARTS  level interrupt to each hart

Behaviour:
- CSR map, per hart, with csr_hart selecting the bank:
  - 0xF20 WBASE[8:0]
  - 0xF21 IBASE[14:0]
  - 0xF22 OBASE[14:0]
  - 0xF23 WPREC[5:0]
  - 0xF24 IPREC[5:0]
  - 0xF25 OPREC[5:0]
  - 0xF26 QMSB[4:0]
  - 0xF27 COUNTDOWN[14:0]
  - 0xF28 COMMAND: write-only, any write launches a job; reads as 0
  - 0xF29 STATUS:
    - bit0 irq_pending (read; write 1 clears)
    - bit1 busy (read-only)
    - bit2 irq_en (read/write)
    - bit3 cmd_err (read; write 1 clears)
- Unused bits read 0. Writes are truncated to field width.
- Unmapped addresses read 0; writes to them are ignored.
- Writes take effect at the clock edge where csr_wr_en is high.
- Reads: csr_rdata is registered and reflects register state before any same-cycle write. csr_rdata is 0 when csr_rd_en was low.
- Config registers drive the mvu_* buses directly, no extra latency.
- COMMAND write, when busy=0 or mvu_done of that MVU is high in the same cycle:
  - mvu_start of that MVU pulses high for exactly one cycle, on the next cycle.
  - busy is set.
- COMMAND write while busy=1 and no same-cycle done: no start pulse; cmd_err is set.
- Config register writes while busy=1 are ignored, except STATUS.
- mvu_done of an MVU:
  - busy clears, unless it is accepting a same-cycle COMMAND, in which case busy stays 1.
  - irq_pending sets.
- mvu_done while busy=0: irq_pending still sets.
- Same-cycle done and irq_pending clear write: the set wins, so irq_pending stays 1.
- irq[h] = irq_pending[h] & irq_en[h], combinational from registers.
- Banks are fully independent: same-cycle done on several MVUs is handled in parallel. Only one CSR access per cycle is possible.
- Reset: all registers 0. csr_rdata=0, mvu_start=0, irq=0, all mvu_* buses 0. Reset has priority over any CSR access or done.
- Reset during a job: busy clears. A later mvu_done only sets irq_pending.

Test Plan:
- Reset then read STATUS of hart 0 → csr_rdata=0 one cycle after read; irq=0, mvu_start=0.
- Hart 3 writes WBASE=0x1FF, IBASE=0x7FFF, OPREC=0x3F, COUNTDOWN=0xFFFF → mvu_wbaseaddr[35:27]=0x1FF, mvu_ibaseaddr[59:45]=0x7FFF, mvu_oprecision[23:18]=0x3F, mvu_countdown[59:45]=0x7FFF (truncated); readback matches; hart 2 bank remains 0.
- Hart 5 writes COMMAND → mvu_start=0x20 for exactly one cycle next cycle; STATUS=0x2. Second COMMAND before done → no pulse; STATUS=0xA. Config write while busy → ignored.
- Hart 5: set irq_en, then pulse mvu_done[5] → busy=0, irq[5]=1. Write STATUS=0x5 → irq[5]=0, irq_en kept (STATUS=0x4). Repeat with done and clear in the same cycle → irq[5] stays 1.
- Hart 1 busy; COMMAND write in the same cycle as mvu_done[1] → start pulse next cycle, busy stays 1, irq_pending=1, cmd_err=0.
- Hart 7 busy with irq_en set; assert rst for 1 cycle → all outputs 0, STATUS=0. Then mvu_done[7] → irq_pending=1 with irq[7]=0 (irq_en cleared).
